// File: rtl/ascon_dec_collector.sv
// ascon_dec_collector
//   Deserialises the plaintext and computed tag streamed out of the Ascon
//   decryption core, compares the tag with a host-supplied expected tag and
//   presents the result behind a done/ack handshake.
//
//   Optional build macro: ASCON_PT_ZEROIZE_EN
//     defined   - plaintext output is forced to zero when the tag mismatches
//     undefined - plaintext output is always the collected plaintext
//
// Ports
//   clk                  system clock
//   rst                  asynchronous reset, active low
//   decryption_readyxSI  core ready level; its rising edge starts a collection
//   plain_textxSI        serial plaintext bit, LSB first
//   tagxSI               serial tag bit, LSB first
//   exp_tagxSI [T]       expected tag, sampled on the ready rising edge
//   ackxSI               host acknowledge of the result
//   plain_textxSO [Y]    collected plaintext
//   tagxSO [T]           collected tag
//   auth_okxSO           collected tag equals the sampled expected tag
//   donexSO              result valid, held until acknowledged
//   busyxSO              collection in progress
module ascon_dec_collector #(
  parameter int unsigned Y     = 40,
  parameter int unsigned T     = 128,
  parameter int unsigned DELAY = 4    // must be >= 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         decryption_readyxSI,
  input  logic         plain_textxSI,
  input  logic         tagxSI,
  input  logic [T-1:0] exp_tagxSI,
  input  logic         ackxSI,
  output logic [Y-1:0] plain_textxSO,
  output logic [T-1:0] tagxSO,
  output logic         auth_okxSO,
  output logic         donexSO,
  output logic         busyxSO
);

  localparam int unsigned M  = (Y > T) ? Y : T;
  localparam int unsigned CW = $clog2(M) + 1;
  localparam int unsigned WW = (DELAY > 2) ? $clog2(DELAY) : 1;

  localparam logic [CW-1:0] YLim  = CW'(Y);
  localparam logic [CW-1:0] TLim  = CW'(T);
  localparam logic [CW-1:0] MLast = CW'(M - 1);
  // The edge cycle counts as the first delay cycle, so WAIT lasts DELAY-1 cycles.
  localparam logic [WW-1:0] WLast = WW'((DELAY > 1) ? (DELAY - 2) : 0);
  localparam bit            SkipWait = (DELAY <= 1);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StShift,
    StCompare,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic          ready_q;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [Y-1:0]  pt_sr_q, pt_sr_d;
  logic [T-1:0]  tag_sr_q, tag_sr_d;
  logic [T-1:0]  exp_q, exp_d;
  logic [Y-1:0]  pt_out_q, pt_out_d;
  logic [T-1:0]  tag_out_q, tag_out_d;
  logic          auth_q, auth_d;
  logic          ready_edge;
  logic          tag_match;

  assign ready_edge = decryption_readyxSI & ~ready_q;
  assign tag_match  = (tag_sr_q == exp_q);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    pt_sr_d   = pt_sr_q;
    tag_sr_d  = tag_sr_q;
    exp_d     = exp_q;
    pt_out_d  = pt_out_q;
    tag_out_d = tag_out_q;
    auth_d    = auth_q;

    unique case (state_q)
      StIdle: begin
        if (ready_edge) begin
          exp_d    = exp_tagxSI;
          pt_sr_d  = '0;
          tag_sr_d = '0;
          wait_d   = '0;
          cnt_d    = '0;
          state_d  = SkipWait ? StShift : StWait;
        end
      end
      StWait: begin
        if (wait_q == WLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StShift: begin
        // Single-bit insert at position cnt_q; streams shorter than M stop early.
        if (cnt_q < YLim) begin
          pt_sr_d = (pt_sr_q & ~(Y'(1'b1) << cnt_q)) | (Y'(plain_textxSI) << cnt_q);
        end
        if (cnt_q < TLim) begin
          tag_sr_d = (tag_sr_q & ~(T'(1'b1) << cnt_q)) | (T'(tagxSI) << cnt_q);
        end
        if (cnt_q == MLast) begin
          cnt_d   = '0;
          state_d = StCompare;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StCompare: begin
        auth_d    = tag_match;
        tag_out_d = tag_sr_q;
`ifdef ASCON_PT_ZEROIZE_EN
        // Never release plaintext that failed authentication.
        pt_out_d  = tag_match ? pt_sr_q : '0;
`else
        pt_out_d  = pt_sr_q;
`endif
        state_d   = StDone;
      end
      StDone: begin
        if (ackxSI) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      wait_q    <= '0;
      cnt_q     <= '0;
      pt_sr_q   <= '0;
      tag_sr_q  <= '0;
      exp_q     <= '0;
      pt_out_q  <= '0;
      tag_out_q <= '0;
      auth_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= decryption_readyxSI;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      pt_sr_q   <= pt_sr_d;
      tag_sr_q  <= tag_sr_d;
      exp_q     <= exp_d;
      pt_out_q  <= pt_out_d;
      tag_out_q <= tag_out_d;
      auth_q    <= auth_d;
    end
  end

  assign plain_textxSO = pt_out_q;
  assign tagxSO        = tag_out_q;
  assign auth_okxSO    = auth_q;
  assign donexSO       = (state_q == StDone);
  assign busyxSO       = (state_q == StWait) || (state_q == StShift) || (state_q == StCompare);

endmodule

// File: doc/ascon_dec_collector.md
Name: ascon_dec_collector

Overview:
- Sits directly downstream of the Ascon decryption core; consumes its serial outputs `plain_textxSO`, `tagxSO` and `decryption_readyxSO`.
- Deserialises the recovered plaintext and the computed tag, then compares the tag against an expected tag supplied by the host.
- Presents parallel plaintext, tag and authentication result to the host behind a done/ack handshake.

Parameters:
- Y, 40, plaintext length in bits (matches core `y`).
- T, 128, tag length in bits.
- DELAY, 4, cycles between the detected ready rising edge and the first valid serial bit.

Ports:
- clk  input  1  single system clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- decryption_readyxSI  input  1  core ready level (core `decryption_readyxSO`).
- plain_textxSI  input  1  serial plaintext bit (core `plain_textxSO`).
- tagxSI  input  1  serial tag bit (core `tagxSO`).
- exp_tagxSI  input  T  expected tag, parallel; sampled on the ready rising edge.
- ackxSI  input  1  host acknowledge of result.
- plain_textxSO  output  Y  collected plaintext.
- tagxSO  output  T  collected tag.
- auth_okxSO  output  1  1 when the collected tag equals the sampled expected tag.
- donexSO  output  1  result valid; held until acknowledged.
- busyxSO  output  1  collection in progress.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; counters 0; expected-tag register 0.
- Ready edge detection: registered copy of decryption_readyxSI; edge = ready & ~ready_q. The edge is acted on only in IDLE; edges in any other state are ignored.
- IDLE:
  - On edge: sample exp_tagxSI; clear plain_text/tag shift registers; go to WAIT with wait counter = 0; busyxSO=1.
- WAIT:
  - Count DELAY-1 cycles (DELAY=4 gives 4 cycles: edge cycle plus 3 more), then go to SHIFT with bit index i=0.
  - DELAY=0 is illegal.
- SHIFT: bit counter i runs 0..M-1, where M=max(Y,T); width is clog2(M)+1.
  - Each cycle: if i<Y, plain_text[i] <= plain_textxSI; if i<T, tag[i] <= tagxSI.
  - Capture is LSB-first: bit 0 arrives first.
  - At i=M-1: capture the final bit, then go to COMPARE.
- COMPARE (one cycle):
  - auth_q <= (tag == exp_tag).
  - Drive plain_textxSO / tagxSO from the shift registers (see Optional Feature).
  - Go to DONE.
- DONE:
  - donexSO=1, busyxSO=0, outputs stable.
  - On ackxSI=1: donexSO <= 0 next cycle; go to IDLE.
  - Outputs keep their values until the next collection's COMPARE.
- Latency: edge to donexSO=1 is DELAY + M + 1 cycles (133 for the defaults).
- ackxSI outside DONE: ignored.
- Ack in the same cycle as a new ready edge: ack is taken, and the edge is ignored because the state is not IDLE. The host must re-pulse ready.
- decryption_readyxSI dropping mid-collection: no effect; collection completes.
- Reset mid-operation: immediate return to IDLE; partial data is discarded and outputs are zeroed.
- busyxSO and donexSO are never 1 simultaneously.

Optional Feature:
- Macro: ASCON_PT_ZEROIZE_EN.
- Defined: on tag mismatch in COMPARE, plain_textxSO is forced to all zeros and tagxSO is still presented. On a match, the plaintext is released normally. This is release-of-unverified-plaintext protection.
- Undefined: plain_textxSO is always the collected plaintext regardless of the tag result; only auth_okxSO reports the mismatch.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, release -> all outputs 0, busyxSO=0, donexSO=0.
- Matching tag:
  - Stimulus: ready edge with exp_tagxSI=128'h0123456789abcdeffedcba9876543210; after 4 cycles serialise PT 40'hc21061905f and that tag LSB-first.
  - Required: donexSO=1 exactly 133 cycles after the edge; plain_textxSO=40'hc21061905f; auth_okxSO=1.
- Mismatch:
  - Stimulus: same as above but flip tag bit 127.
  - Required: auth_okxSO=0; plain_textxSO=0 with ASCON_PT_ZEROIZE_EN defined, and 40'hc21061905f without it.
- Handshake:
  - Hold ackxSI=0 for 20 cycles -> donexSO stays 1 with outputs stable.
  - Pulse ackxSI -> donexSO=0 the next cycle; a second ready edge then starts a new collection.
- Ignored edges: toggle decryption_readyxSI 0→1 during SHIFT (i=50) -> no restart; result matches the first collection.
- Reset mid-SHIFT: drive rst=0 at i=20 -> outputs 0 immediately, state IDLE; a following full sequence completes with the correct result.
